// File: rtl/rv_decode_exec.sv
// rv_decode_exec: RV32 subset decode, operand select and ALU, with a
// one-deep EX->MEM output register stage.
// Optional feature: define BRANCH_CMP_EN to add a registered branch_taken
// output. It is set for a valid BEQ whose operands compare equal.
module rv_decode_exec #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    input  logic            stall,
    input  logic [31:0]     instr,
    input  logic [XLEN-1:0] pc,
    input  logic [XLEN-1:0] rs1_data,
    input  logic [XLEN-1:0] rs2_data,
    output logic [4:0]      rs1_addr,
    output logic [4:0]      rs2_addr,
    output logic            out_valid,
    output logic [XLEN-1:0] result,
    output logic [XLEN-1:0] store_data,
    output logic [XLEN-1:0] link_data,
    output logic [4:0]      rd,
    output logic            reg_write,
    output logic            load,
    output logic            store,
    output logic            jump,
    output logic            illegal
`ifdef BRANCH_CMP_EN
    ,
    output logic            branch_taken
`endif
);

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_XOR = 3'b100;
    localparam logic [2:0] ALU_SLL = 3'b101;
    localparam logic [2:0] ALU_SRL = 3'b110;
    localparam logic [2:0] ALU_SLT = 3'b111;

    // Instruction fields
    logic [6:0]  opcode;
    logic [2:0]  funct3;
    logic        funct7_b5;
    logic [11:0] imm_i;
    logic [11:0] imm_s;
    logic [11:0] imm_b;
    logic [19:0] imm_j;

    assign opcode    = instr[6:0];
    assign funct3    = instr[14:12];
    assign funct7_b5 = instr[30];
    assign rs1_addr  = instr[19:15];
    assign rs2_addr  = instr[24:20];
    assign imm_i     = instr[31:20];
    assign imm_s     = {instr[31:25], instr[11:7]};
    assign imm_b     = {instr[31], instr[7], instr[30:25], instr[11:8]};
    assign imm_j     = {instr[31], instr[19:12], instr[20], instr[30:21]};

    // Decoded controls and operands
    logic            is_r;
    logic            is_i;
    logic            is_load;
    logic            is_store;
    logic            is_branch;
    logic            is_jal;
    logic            known_op;
    logic [2:0]      alusel;
    logic [XLEN-1:0] op1;
    logic [XLEN-1:0] op2;
    logic [XLEN-1:0] alu_out;
    logic            writes_rd;

    // Opcode class decode
    always_comb begin
        is_r      = (opcode == OP_R);
        is_i      = (opcode == OP_I);
        is_load   = (opcode == OP_LOAD);
        is_store  = (opcode == OP_STORE);
        is_branch = (opcode == OP_BRANCH);
        is_jal    = (opcode == OP_JAL);
        known_op  = is_r | is_i | is_load | is_store | is_branch | is_jal;
        writes_rd = (is_r | is_i | is_load | is_jal) && (instr[11:7] != 5'd0);
    end

    // ALU operation select; only register-register ops honour funct7 for SUB,
    // and shifts right are always logical since there is no arithmetic shift
    always_comb begin
        alusel = ALU_ADD;
        if (is_r || is_i) begin
            case (funct3)
                3'b000:  alusel = (is_r && funct7_b5) ? ALU_SUB : ALU_ADD;
                3'b111:  alusel = ALU_AND;
                3'b110:  alusel = ALU_OR;
                3'b100:  alusel = ALU_XOR;
                3'b001:  alusel = ALU_SLL;
                3'b101:  alusel = ALU_SRL;
                3'b010:  alusel = ALU_SLT;
                default: alusel = ALU_ADD;
            endcase
        end
    end

    // Operand select; branch and jump targets are pc-relative
    always_comb begin
        op1 = '0;
        op2 = '0;
        if (is_r) begin
            op1 = rs1_data;
            op2 = rs2_data;
        end else if (is_i || is_load) begin
            op1 = rs1_data;
            op2 = {{20{imm_i[11]}}, imm_i};
        end else if (is_store) begin
            op1 = rs1_data;
            op2 = {{20{imm_s[11]}}, imm_s};
        end else if (is_branch) begin
            op1 = pc;
            op2 = {{19{imm_b[11]}}, imm_b, 1'b0};
        end else if (is_jal) begin
            op1 = pc;
            op2 = {{11{imm_j[19]}}, imm_j, 1'b0};
        end
    end

    // ALU datapath, wrap-around arithmetic with no flags
    always_comb begin
        alu_out = '0;
        case (alusel)
            ALU_ADD: alu_out = op1 + op2;
            ALU_SUB: alu_out = op1 - op2;
            ALU_AND: alu_out = op1 & op2;
            ALU_OR:  alu_out = op1 | op2;
            ALU_XOR: alu_out = op1 ^ op2;
            ALU_SLL: alu_out = op1 << op2[4:0];
            ALU_SRL: alu_out = op1 >> op2[4:0];
            ALU_SLT: alu_out = ($signed(op1) < $signed(op2)) ? 32'd1 : 32'd0;
            default: alu_out = op1 + op2;
        endcase
    end

    // EX->MEM stage register: flags gated by in_valid, everything holds on stall
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid  <= 1'b0;
            result     <= '0;
            store_data <= '0;
            link_data  <= '0;
            rd         <= '0;
            reg_write  <= 1'b0;
            load       <= 1'b0;
            store      <= 1'b0;
            jump       <= 1'b0;
            illegal    <= 1'b0;
        end else if (!stall) begin
            out_valid  <= in_valid;
            result     <= alu_out;
            store_data <= rs2_data;
            link_data  <= pc + 32'd4;
            rd         <= instr[11:7];
            reg_write  <= in_valid & writes_rd;
            load       <= in_valid & is_load;
            store      <= in_valid & is_store;
            jump       <= in_valid & is_jal;
            illegal    <= in_valid & ~known_op;
        end
    end

`ifdef BRANCH_CMP_EN
    logic beq_hit;
    assign beq_hit = in_valid && is_branch && (funct3 == 3'b000) && (rs1_data == rs2_data);

    // Registered BEQ outcome, aligned with the rest of the stage register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            branch_taken <= 1'b0;
        end else if (!stall) begin
            branch_taken <= beq_hit;
        end
    end
`endif

endmodule

// File: tb/tb_rv_decode_exec.sv
// tb_rv_decode_exec: directed, table-driven check of rv_decode_exec plus
// hand-written stall and asynchronous reset sequences.
// Builds with or without BRANCH_CMP_EN.
module tb_rv_decode_exec;

    logic        clk;
    logic        rst_n;
    logic        in_valid;
    logic        stall;
    logic [31:0] instr;
    logic [31:0] pc;
    logic [31:0] rs1_data;
    logic [31:0] rs2_data;
    logic [4:0]  rs1_addr;
    logic [4:0]  rs2_addr;
    logic        out_valid;
    logic [31:0] result;
    logic [31:0] store_data;
    logic [31:0] link_data;
    logic [4:0]  rd;
    logic        reg_write;
    logic        load;
    logic        store;
    logic        jump;
    logic        illegal;
`ifdef BRANCH_CMP_EN
    logic        branch_taken;
`endif

    int n_cmp = 0;
    int n_bad = 0;

    rv_decode_exec #(.XLEN(32)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .stall      (stall),
        .instr      (instr),
        .pc         (pc),
        .rs1_data   (rs1_data),
        .rs2_data   (rs2_data),
        .rs1_addr   (rs1_addr),
        .rs2_addr   (rs2_addr),
        .out_valid  (out_valid),
        .result     (result),
        .store_data (store_data),
        .link_data  (link_data),
        .rd         (rd),
        .reg_write  (reg_write),
        .load       (load),
        .store      (store),
        .jump       (jump),
        .illegal    (illegal)
`ifdef BRANCH_CMP_EN
        ,
        .branch_taken (branch_taken)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        string       name;
        logic        valid;
        logic [31:0] ins;
        logic [31:0] pcv;
        logic [31:0] r1;
        logic [31:0] r2;
        logic        chk_data;
        logic [31:0] e_res;
        logic [4:0]  e_rd;
        logic        e_rw;
        logic        e_ld;
        logic        e_st;
        logic        e_jp;
        logic        e_ill;
        logic        e_bt;
    } vec_t;

    vec_t vecs[16];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Every registered output must read zero
    task automatic check_all_zero(input string tag);
        check({tag, ".out_valid"}, {31'd0, out_valid}, 32'd0);
        check({tag, ".result"}, result, 32'd0);
        check({tag, ".store_data"}, store_data, 32'd0);
        check({tag, ".link_data"}, link_data, 32'd0);
        check({tag, ".rd"}, {27'd0, rd}, 32'd0);
        check({tag, ".flags"}, {27'd0, reg_write, load, store, jump, illegal}, 32'd0);
`ifdef BRANCH_CMP_EN
        check({tag, ".branch_taken"}, {31'd0, branch_taken}, 32'd0);
`endif
    endtask

    task automatic drive(input logic v, input logic [31:0] i, input logic [31:0] p,
                         input logic [31:0] a, input logic [31:0] b);
        in_valid = v;
        instr    = i;
        pc       = p;
        rs1_data = a;
        rs2_data = b;
    endtask

    initial begin
        // name, valid, instr, pc, rs1, rs2, chk_data, result, rd, rw, ld, st, jp, ill, bt
        vecs[0]  = '{"add",      1, 32'h002081B3, 32'h0,  32'd5,        32'd7,        1, 32'd12,        5'd3, 1, 0, 0, 0, 0, 0};
        vecs[1]  = '{"sub",      1, 32'h402081B3, 32'h4,  32'd3,        32'd5,        1, 32'hFFFFFFFE,  5'd3, 1, 0, 0, 0, 0, 0};
        vecs[2]  = '{"slt",      1, 32'h0020A1B3, 32'h8,  32'd3,        32'd5,        1, 32'd1,         5'd3, 1, 0, 0, 0, 0, 0};
        vecs[3]  = '{"srl",      1, 32'h0020D1B3, 32'hC,  32'h80000000, 32'd31,       1, 32'd1,         5'd3, 1, 0, 0, 0, 0, 0};
        vecs[4]  = '{"lw",       1, 32'hFFC0A283, 32'h10, 32'h100,      32'h55,       1, 32'hFC,        5'd5, 1, 1, 0, 0, 0, 0};
        vecs[5]  = '{"jal",      1, 32'h008000EF, 32'h40, 32'h77,       32'h66,       1, 32'h48,        5'd1, 1, 0, 0, 1, 0, 0};
        vecs[6]  = '{"sw",       1, 32'h0020A423, 32'h50, 32'h200,      32'hDEADBEEF, 1, 32'h208,       5'd8, 0, 0, 1, 0, 0, 0};
        vecs[7]  = '{"addi_x0",  1, 32'h00108013, 32'h54, 32'd4,        32'd9,        1, 32'd5,         5'd0, 0, 0, 0, 0, 0, 0};
        vecs[8]  = '{"xori",     1, 32'hFFF0C213, 32'h58, 32'h0F0F0F0F, 32'd0,        1, 32'hF0F0F0F0,  5'd4, 1, 0, 0, 0, 0, 0};
        vecs[9]  = '{"illegal",  1, 32'h0000007F, 32'h5C, 32'd1,        32'd2,        1, 32'd0,         5'd0, 0, 0, 0, 0, 1, 0};
        vecs[10] = '{"beq_eq",   1, 32'h00208863, 32'h20, 32'd9,        32'd9,        1, 32'h30,        5'd16, 0, 0, 0, 0, 0, 1};
        vecs[11] = '{"beq_ne",   1, 32'h00208863, 32'h20, 32'd9,        32'd8,        1, 32'h30,        5'd16, 0, 0, 0, 0, 0, 0};
        vecs[12] = '{"sll",      1, 32'h002091B3, 32'h60, 32'd1,        32'h24,       1, 32'd16,        5'd3, 1, 0, 0, 0, 0, 0};
        vecs[13] = '{"and",      1, 32'h0020F1B3, 32'h64, 32'hFF00FF00, 32'h0FF00FF0, 1, 32'h0F000F00,  5'd3, 1, 0, 0, 0, 0, 0};
        vecs[14] = '{"slt_neg",  1, 32'h0020A1B3, 32'h68, 32'hFFFFFFFF, 32'd1,        1, 32'd1,         5'd3, 1, 0, 0, 0, 0, 0};
        vecs[15] = '{"nop_lw",   0, 32'hFFC0A283, 32'h6C, 32'h100,      32'h0,        0, 32'h0,         5'd5, 0, 0, 0, 0, 0, 0};

        rst_n = 1'b0;
        stall = 1'b0;
        drive(1'b0, 32'h0, 32'h0, 32'h0, 32'h0);
        #12;
        check_all_zero("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Table-driven single-cycle vectors
        for (int i = 0; i < 16; i++) begin
            drive(vecs[i].valid, vecs[i].ins, vecs[i].pcv, vecs[i].r1, vecs[i].r2);
            @(posedge clk);
            #1;
            check({vecs[i].name, ".out_valid"}, {31'd0, out_valid}, {31'd0, vecs[i].valid});
            check({vecs[i].name, ".flags"}, {27'd0, reg_write, load, store, jump, illegal},
                  {27'd0, vecs[i].e_rw, vecs[i].e_ld, vecs[i].e_st, vecs[i].e_jp, vecs[i].e_ill});
            if (vecs[i].chk_data) begin
                check({vecs[i].name, ".result"}, result, vecs[i].e_res);
                check({vecs[i].name, ".rd"}, {27'd0, rd}, {27'd0, vecs[i].e_rd});
                check({vecs[i].name, ".store_data"}, store_data, vecs[i].r2);
                check({vecs[i].name, ".link_data"}, link_data, vecs[i].pcv + 32'd4);
            end
`ifdef BRANCH_CMP_EN
            check({vecs[i].name, ".branch_taken"}, {31'd0, branch_taken}, {31'd0, vecs[i].e_bt});
`endif
            $display("vec %-8s instr=%08h result=%08h rd=%0d valid=%0b", vecs[i].name,
                     vecs[i].ins, result, rd, out_valid);
        end

        // Combinational register-address split
        drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);
        #1;
        check("rs_addr", {22'd0, rs1_addr, rs2_addr}, {22'd0, 5'd1, 5'd2});
        @(posedge clk);
        #1;
        check("pre_stall.result", result, 32'd12);

        // Stall for three cycles with a different valid instruction offered
        stall = 1'b1;
        drive(1'b1, 32'h008000EF, 32'h40, 32'd3, 32'd5);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            #1;
            check("stall.result", result, 32'd12);
            check("stall.rd", {27'd0, rd}, 32'd3);
            check("stall.ctl", {26'd0, out_valid, reg_write, load, store, jump, illegal}, 32'b110000);
            check("stall.link", link_data, 32'd4);
            $display("stall cycle %0d result=%08h rd=%0d", c, result, rd);
        end
        stall = 1'b0;
        @(posedge clk);
        #1;
        check("post_stall.result", result, 32'h48);
        check("post_stall.jump", {31'd0, jump}, 32'd1);
        $display("post-stall result=%08h jump=%0b", result, jump);

        // Asynchronous reset in the middle of a cycle
        drive(1'b1, 32'h002081B3, 32'h0, 32'd5, 32'd7);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check_all_zero("async_rst");
        @(posedge clk);
        #1;
        check_all_zero("rst_held");
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check_all_zero("rst_release");
        @(posedge clk);
        #1;
        check("first_capture.result", result, 32'd12);
        check("first_capture.valid", {31'd0, out_valid}, 32'd1);
        $display("after reset result=%08h valid=%0b", result, out_valid);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
